// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing for the HDMI transmit path.
// Produces pixel coordinates, active-video enable, sync and line/frame
// start pulses on pixclk; all outputs are registered and mutually aligned
// (one pixclk behind the internal h_cnt/v_cnt counters).
// Optional colour-bar test pattern: define VIDEO_TIMING_TEST_PATTERN_EN to
// add red/green/blue outputs carrying eight vertical bars.
module video_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int H_POL    = 0,
    parameter int V_POL    = 0
) (
    input  logic        pixclk,
    input  logic        reset,
    input  logic        enable,
    output logic [11:0] counter_x,
    output logic [11:0] counter_y,
    output logic        draw_area,
    output logic        hsync,
    output logic        vsync,
    output logic        line_start,
    output logic        frame_start
`ifdef VIDEO_TIMING_TEST_PATTERN_EN
    ,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);

    // Region bounds are 13 bits so a total of exactly 4096 cannot alias to 0.
    localparam logic [12:0] H_ACT_END = 13'(H_ACTIVE);
    localparam logic [12:0] HS_BEG    = 13'(H_ACTIVE + H_FP);
    localparam logic [12:0] HS_END    = 13'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [12:0] V_ACT_END = 13'(V_ACTIVE);
    localparam logic [12:0] VS_BEG    = 13'(V_ACTIVE + V_FP);
    localparam logic [12:0] VS_END    = 13'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic HS_LVL = (H_POL != 0);
    localparam logic VS_LVL = (V_POL != 0);

    logic [11:0] h_cnt;
    logic [11:0] v_cnt;
    logic [11:0] h_next;
    logic [11:0] v_next;
    logic        h_wrap;
    logic [12:0] h_ext;
    logic [12:0] v_ext;
    logic        active;
    logic        hs_on;
    logic        vs_on;

    // Next raster position: h wraps at end of line, v advances only on that wrap.
    always_comb begin
        h_wrap = (h_cnt == H_LAST);
        h_next = h_wrap ? 12'd0 : h_cnt + 12'd1;
        v_next = v_cnt;
        if (h_wrap) begin
            v_next = (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
        end
    end

    // Region decode of the current (unregistered) position.
    always_comb begin
        h_ext  = {1'b0, h_cnt};
        v_ext  = {1'b0, v_cnt};
        active = (h_ext < H_ACT_END) && (v_ext < V_ACT_END);
        hs_on  = (h_ext >= HS_BEG) && (h_ext < HS_END);
        vs_on  = (v_ext >= VS_BEG) && (v_ext < VS_END);
    end

    // Position counters; enable low freezes the raster.
    always_ff @(posedge pixclk or posedge reset) begin
        if (reset) begin
            h_cnt <= 12'd0;
            v_cnt <= 12'd0;
        end else if (enable) begin
            h_cnt <= h_next;
            v_cnt <= v_next;
        end
    end

    // Registered outputs, all sampled from the same h_cnt/v_cnt so they stay aligned.
    always_ff @(posedge pixclk or posedge reset) begin
        if (reset) begin
            counter_x   <= 12'd0;
            counter_y   <= 12'd0;
            draw_area   <= 1'b0;
            hsync       <= ~HS_LVL;
            vsync       <= ~VS_LVL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (enable) begin
            counter_x   <= h_cnt;
            counter_y   <= v_cnt;
            draw_area   <= active;
            hsync       <= hs_on ? HS_LVL : ~HS_LVL;
            vsync       <= vs_on ? VS_LVL : ~VS_LVL;
            line_start  <= (h_cnt == 12'd0);
            frame_start <= (h_cnt == 12'd0) && (v_cnt == 12'd0);
        end
    end

`ifdef VIDEO_TIMING_TEST_PATTERN_EN
    // Each bar is H_ACTIVE/8 pixels; bar_left is a down-counter that reloads
    // on terminal count, so no divider is needed to find the bar index.
    localparam logic [11:0] BAR_LAST = 12'(H_ACTIVE / 8 - 1);

    logic [2:0]  bar_idx;
    logic [11:0] bar_left;

    // Bar index tracks h_cnt; it restarts with the line and is don't-care in blanking.
    always_ff @(posedge pixclk or posedge reset) begin
        if (reset) begin
            bar_idx  <= 3'd0;
            bar_left <= BAR_LAST;
        end else if (enable) begin
            if (h_wrap) begin
                bar_idx  <= 3'd0;
                bar_left <= BAR_LAST;
            end else if (bar_left == 12'd0) begin
                bar_idx  <= bar_idx + 3'd1;
                bar_left <= BAR_LAST;
            end else begin
                bar_left <= bar_left - 12'd1;
            end
        end
    end

    // Bar order white, yellow, cyan, green, magenta, red, blue, black maps to
    // R = !idx[1], G = !idx[2], B = !idx[0]; blanked outside the active region.
    always_ff @(posedge pixclk or posedge reset) begin
        if (reset) begin
            red   <= 8'h00;
            green <= 8'h00;
            blue  <= 8'h00;
        end else if (enable) begin
            red   <= (active && !bar_idx[1]) ? 8'hFF : 8'h00;
            green <= (active && !bar_idx[2]) ? 8'hFF : 8'h00;
            blue  <= (active && !bar_idx[0]) ? 8'hFF : 8'h00;
        end
    end
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed testbench for video_timing_gen. Horizontal timing uses the
// 640-wide defaults (800-pixel lines); vertical timing is shortened to
// 6 active lines + 2 FP + 2 sync + 3 BP = 13 lines so a full frame is short.
module tb_video_timing_gen;

    logic        pixclk = 1'b0;
    logic        reset  = 1'b1;
    logic        enable = 1'b1;
    logic [11:0] counter_x;
    logic [11:0] counter_y;
    logic        draw_area;
    logic        hsync;
    logic        vsync;
    logic        line_start;
    logic        frame_start;
`ifdef VIDEO_TIMING_TEST_PATTERN_EN
    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;
`endif

    int errors = 0;
    int checks = 0;

    video_timing_gen #(
        .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_ACTIVE(6),   .V_FP(2),  .V_SYNC(2),  .V_BP(3),
        .H_POL(0),      .V_POL(0)
    ) dut (
        .pixclk     (pixclk),
        .reset      (reset),
        .enable     (enable),
        .counter_x  (counter_x),
        .counter_y  (counter_y),
        .draw_area  (draw_area),
        .hsync      (hsync),
        .vsync      (vsync),
        .line_start (line_start),
        .frame_start(frame_start)
`ifdef VIDEO_TIMING_TEST_PATTERN_EN
        ,
        .red        (red),
        .green      (green),
        .blue       (blue)
`endif
    );

    always #5 pixclk = ~pixclk;

    task automatic tick();
        @(posedge pixclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] snap();
        return 32'({counter_x, counter_y, draw_area, hsync, vsync, line_start, frame_start});
    endfunction

    initial begin
        int ls_last, ls_period, fs_idx, prev_y;
        int hs_low, hs_first, hs_last, de_cnt;
        int vs_low, vs_first_y, vs_last_y, vs_bad_edge, bad_align, col_bad;
        int x, y, ex, ey;
        logic prev_vs, wrap_ok, reached;
        logic [23:0] bars [8];
        logic [23:0] exp_col;

        bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

        // Held in reset across a few edges.
        tick(); tick();
        chk("rst_x",  32'(counter_x), 0);
        chk("rst_y",  32'(counter_y), 0);
        chk("rst_de", 32'(draw_area), 0);
        chk("rst_hs", 32'(hsync), 1);
        chk("rst_vs", 32'(vsync), 1);
        chk("rst_ls", 32'(line_start), 0);
        chk("rst_fs", 32'(frame_start), 0);
`ifdef VIDEO_TIMING_TEST_PATTERN_EN
        chk("rst_rgb", 32'({red, green, blue}), 0);
`endif

        // First enabled cycle after release shows position (0,0).
        reset = 1'b0;
        tick();
        chk("first_out", snap(), 32'({12'd0, 12'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1}));

        // One full frame, measuring sync widths, periods and alignment.
        ls_last = 0; ls_period = -1; fs_idx = -1; prev_y = 0; wrap_ok = 1'b0;
        hs_low = 0; hs_first = -1; hs_last = -1; de_cnt = 1;
        vs_low = 0; vs_first_y = -1; vs_last_y = -1; vs_bad_edge = 0;
        bad_align = 0; col_bad = 0; prev_vs = 1'b1;
        for (int i = 1; i <= 10400; i++) begin
            tick();
            x = int'(counter_x);
            y = int'(counter_y);
            ex = i % 800;
            ey = (i / 800) % 13;
            if (x != ex || y != ey) bad_align++;
            if (draw_area !== (ex < 640 && ey < 6)) bad_align++;
            if (hsync !== !(ex >= 656 && ex < 752)) bad_align++;
            if (vsync !== !(ey >= 8 && ey < 10)) bad_align++;
            if (line_start !== (ex == 0)) bad_align++;
            if (frame_start !== (ex == 0 && ey == 0)) bad_align++;
            if (i < 800) begin
                if (hsync === 1'b0) begin
                    hs_low++;
                    if (hs_first < 0) hs_first = x;
                    hs_last = x;
                end
                if (draw_area === 1'b1) de_cnt++;
            end
            if (vsync === 1'b0) begin
                vs_low++;
                if (vs_first_y < 0) vs_first_y = y;
                vs_last_y = y;
            end
            if (vsync !== prev_vs && x != 0) vs_bad_edge++;
            prev_vs = vsync;
            if (line_start === 1'b1 && ls_period < 0) ls_period = i - ls_last;
            if (frame_start === 1'b1 && fs_idx < 0) begin
                fs_idx = i;
                wrap_ok = (prev_y == 12) && (y == 0);
            end
            prev_y = y;
`ifdef VIDEO_TIMING_TEST_PATTERN_EN
            exp_col = (ex < 640 && ey < 6) ? bars[ex / 80] : 24'h000000;
            if ({red, green, blue} !== exp_col) col_bad++;
            if (i == 40)  chk("bar_white",  32'({red, green, blue}), 32'h00FFFFFF);
            if (i == 100) chk("bar_yellow", 32'({red, green, blue}), 32'h00FFFF00);
            if (i == 600) chk("bar_black",  32'({red, green, blue}), 32'h00000000);
            if (i == 700) chk("blank_rgb",  32'({red, green, blue}), 32'h00000000);
`endif
        end
        chk("hs_low_cnt",  32'(hs_low), 96);
        chk("hs_first_x",  32'(hs_first), 656);
        chk("hs_last_x",   32'(hs_last), 751);
        chk("de_cnt",      32'(de_cnt), 640);
        chk("ls_period",   32'(ls_period), 800);
        chk("vs_low_cnt",  32'(vs_low), 1600);
        chk("vs_first_y",  32'(vs_first_y), 8);
        chk("vs_last_y",   32'(vs_last_y), 9);
        chk("vs_edge_x0",  32'(vs_bad_edge), 0);
        chk("fs_period",   32'(fs_idx), 10400);
        chk("y_wrap",      32'(wrap_ok), 1);
        chk("raster_align", 32'(bad_align), 0);
`ifdef VIDEO_TIMING_TEST_PATTERN_EN
        chk("colour_bars", 32'(col_bad), 0);
`endif

        // Pulses held high stay high while enable is low.
        enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("freeze_pulse", snap(), 32'({12'd0, 12'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1}));
        end
        enable = 1'b1;
        tick();
        chk("pulse_clear", snap(), 32'({12'd1, 12'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}));

        // Freeze mid-line at x=300 for 5 cycles, then resume at 301.
        for (int k = 0; k < 299; k++) tick();
        chk("at_300", 32'(counter_x), 300);
        enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("freeze_mid", snap(), 32'({12'd300, 12'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}));
        end
        enable = 1'b1;
        tick();
        chk("resume_301", 32'(counter_x), 301);

        // Navigate to x=700,y=5 (inside hsync), then reset asynchronously.
        reached = 1'b0;
        for (int n = 0; n < 6000 && !reached; n++) begin
            tick();
            reached = (counter_x == 12'd700) && (counter_y == 12'd5);
        end
        chk("nav_reach", 32'(reached), 1);
        chk("pre_rst_hs", 32'(hsync), 0);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst", snap(), 32'({12'd0, 12'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}));
        #1;
        reset = 1'b0;
        tick();
        chk("restart_00", snap(), 32'({12'd0, 12'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1}));
        tick();
        chk("restart_x1", 32'(counter_x), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Generates raster timing for the HDMI transmit path: pixel coordinates, active-video enable, and horizontal/vertical sync.
- Runs on the pixel clock and feeds the three TMDS channel encoders directly upstream of them.
- draw_area drives the encoders' de input; {vsync,hsync} drives the blue encoder's ctrl input.
- Fully parameterised; defaults are 640x480@60 (25 MHz pixclk).

Parameters:
H_ACTIVE, 640, visible pixels per line; must be a multiple of 8
H_FP, 16, horizontal front porch in pixels
H_SYNC, 96, horizontal sync width in pixels
H_BP, 48, horizontal back porch in pixels
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch in lines
V_SYNC, 2, vertical sync width in lines
V_BP, 33, vertical back porch in lines
H_POL, 0, hsync active level (0 = active-low)
V_POL, 0, vsync active level (0 = active-low)

Ports:
pixclk  input  1  pixel clock
reset  input  1  asynchronous, active-high reset
enable  input  1  count enable; low freezes the generator
counter_x  output  12  horizontal position, 0..H_TOTAL-1
counter_y  output  12  vertical position, 0..V_TOTAL-1
draw_area  output  1  high inside the active region
hsync  output  1  horizontal sync at H_POL level when asserted
vsync  output  1  vertical sync at V_POL level when asserted
line_start  output  1  one-cycle pulse at counter_x==0
frame_start  output  1  one-cycle pulse at counter_x==0 and counter_y==0

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP. Both totals must be ≤4096 (12-bit counters).
- Internal counters h_cnt and v_cnt.
  - h_cnt increments each enabled cycle and wraps from H_TOTAL-1 to 0.
  - v_cnt increments only when h_cnt wraps, and wraps from V_TOTAL-1 to 0.
- Region decode (combinational on h_cnt/v_cnt):
  - active = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE
  - hs_on = H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC
  - vs_on = V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC
  - vsync transitions only at line boundaries, i.e. coincident with counter_x returning to 0.
- Output timing:
  - All outputs are registered: one pixclk of latency from the counters.
  - All outputs are mutually aligned: counter_x/counter_y are the registered h_cnt/v_cnt values that produced draw_area/hsync/vsync in the same cycle.
- Sync polarity: hsync = hs_on ? H_POL : !H_POL; vsync likewise with V_POL.
- Reset (asynchronous, any time):
  - h_cnt, v_cnt, counter_x, counter_y = 0.
  - draw_area, line_start, frame_start = 0.
  - hsync = !H_POL, vsync = !V_POL.
- After reset release: the first enabled cycle registers position (0,0), so frame_start and line_start are both 1 in that output cycle.
- enable low: counters and all registered outputs hold their values.
  - A pulse output held high stays high while enable is low; a single enabled cycle then clears it.
- Reset mid-frame: the generator restarts at (0,0); no partial-line completion.

Optional Feature:
- Macro: VIDEO_TIMING_TEST_PATTERN_EN.
- When defined, three extra outputs red, green, blue (8 bits each) carry eight vertical colour bars, each H_ACTIVE/8 pixels wide, in this order: white, yellow, cyan, green, magenta, red, blue, black.
  - Channel values are 8'hFF or 8'h00.
  - The bar index comes from a 3-bit counter advancing every H_ACTIVE/8 active pixels (no divider); it resets to 0 at each line start.
  - Colour outputs are registered and aligned with draw_area.
  - Colour outputs are 0 whenever draw_area is 0 and on reset.
- When undefined, the ports and logic are absent; the timing behaviour is identical in both builds.

Test Plan:
- Assert reset, then release with enable=1 → first output cycle shows counter_x=0, counter_y=0, draw_area=1, frame_start=1, line_start=1, hsync=1, vsync=1.
- Run one line (defaults) → hsync=0 exactly for counter_x 656..751 (96 cycles); draw_area=1 for counter_x 0..639; line_start period is 800 cycles.
- Run a full frame → vsync=0 for counter_y 490..491 (1600 cycles); frame_start period is 420000 cycles; counter_y wraps 524→0.
- Drop enable for 5 cycles mid-line at counter_x=300 → all outputs frozen; counter_x resumes at 301 on the next enabled cycle.
- Assert reset at counter_x=700, counter_y=200 → outputs immediately (asynchronously) go to the reset values; after release, counting restarts from 0,0.
- With VIDEO_TIMING_TEST_PATTERN_EN defined → counter_x 0..79 gives FF/FF/FF, 80..159 gives FF/FF/00, 560..639 gives 00/00/00, and blanking gives 0.
